// File: rtl/color_table_pkg.sv
// Shared types, constants and colour helpers for the AGA colour lookup table.
package color_table_pkg;

  localparam int unsigned BANK_LOG2 = 5;
  localparam int unsigned RGB12_W   = 12;
  localparam int unsigned RGB24_W   = 24;

  typedef logic [RGB12_W-1:0] rgb12_t;
  typedef logic [RGB24_W-1:0] rgb24_t;

  // Palette controller states
  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  // Sideband that travels with a read through the pipeline
  typedef struct packed {
    logic valid;
    logic half;
    logic zero;
  } rd_tag_t;

  // {hiR,loR,hiG,loG,hiB,loB}
  function automatic rgb24_t interleave(input rgb12_t hi12, input rgb12_t lo12);
    return {hi12[11:8], lo12[11:8], hi12[7:4], lo12[7:4], hi12[3:0], lo12[3:0]};
  endfunction

  // Extra-Half-Brite: halve every 8-bit channel
  function automatic rgb24_t ehb_half(input rgb24_t c);
    return {1'b0, c[23:17], 1'b0, c[15:9], 1'b0, c[7:1]};
  endfunction

endpackage

// File: rtl/color_table_aga_if.sv
// CPU write port and CLUT read port of the colour table.
interface color_table_aga_if #(
  parameter int unsigned DEPTH_LOG2 = 8
);
  import color_table_pkg::*;

  logic                  cpu_wr;
  logic [2:0]            cpu_bank;
  logic [4:0]            cpu_idx;
  logic                  cpu_loct;
  rgb12_t                cpu_rgb;
  logic                  clut_rd;
  logic [DEPTH_LOG2-1:0] clut_idx;
  logic                  clut_ehb;
  rgb24_t                clut_rgb;
  logic                  clut_valid;
  logic                  init_busy;

  modport master (
    output cpu_wr, cpu_bank, cpu_idx, cpu_loct, cpu_rgb,
    output clut_rd, clut_idx, clut_ehb,
    input  clut_rgb, clut_valid, init_busy
  );

  modport slave (
    input  cpu_wr, cpu_bank, cpu_idx, cpu_loct, cpu_rgb,
    input  clut_rd, clut_idx, clut_ehb,
    output clut_rgb, clut_valid, init_busy
  );

endinterface

// File: rtl/color_table_aga_clut_ram.sv
// Simple dual-port palette half: one write port, one registered read-first read port.
module clut_ram
  import color_table_pkg::*;
#(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  rgb12_t            i_wdata,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_raddr,
  output rgb12_t            o_rdata
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  rgb12_t r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Non-blocking read of the same array gives old data on a same-address write
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o_rdata <= '0;
    end else if (i_re) begin
      o_rdata <= r_mem[i_raddr];
    end
  end

endmodule

// File: rtl/color_table_aga.sv
// Banked 24-bit colour lookup table with nibble writes, EHB reads and a zeroing sweep after reset.
module color_table_aga
  import color_table_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 8,
  parameter bit          EHB_EN     = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  color_table_aga_if.slave  bus
);

  localparam int unsigned WA_FULL_W = 8;
  localparam int unsigned IDX_W     = (DEPTH_LOG2 > 6) ? DEPTH_LOG2 : 6;
  localparam logic [DEPTH_LOG2-1:0] CNT_MAX = '1;

  logic [0:0]            r_state;
  logic [0:0]            w_state_nxt;
  logic [DEPTH_LOG2-1:0] r_cnt;
  logic [DEPTH_LOG2-1:0] w_cnt_nxt;
  logic                  r_init_busy;
  logic                  w_init_busy_nxt;

  logic                  w_run;
  logic [WA_FULL_W-1:0]  w_wa_full;
  logic [DEPTH_LOG2-1:0] w_waddr;
  rgb12_t                w_wdata;
  logic                  w_we_hi;
  logic                  w_we_lo;

  logic [IDX_W-1:0]      w_idx_ext;
  logic [IDX_W-1:0]      w_ra_ext;
  logic [DEPTH_LOG2-1:0] w_raddr;
  logic                  w_ehb_sel;
  logic                  w_half;
  logic                  w_re;

  rgb12_t                w_hi_q;
  rgb12_t                w_lo_q;
  rd_tag_t               r_s1;
  rgb24_t                w_rgb_asm;
  rgb24_t                w_rgb_s2;
  rgb24_t                r_clut_rgb;
  logic                  r_clut_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_INIT;
      r_cnt       <= '0;
      r_init_busy <= 1'b1;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_init_busy <= w_init_busy_nxt;
    end
  end

  // Sweep every entry once, then hand the palette to the CPU
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_init_busy_nxt = r_init_busy;
    case (r_state)
      ST_INIT: begin
        w_cnt_nxt       = r_cnt + DEPTH_LOG2'(1);
        w_init_busy_nxt = 1'b1;
        if (r_cnt == CNT_MAX) begin
          w_state_nxt     = ST_RUN;
          w_cnt_nxt       = '0;
          w_init_busy_nxt = 1'b0;
        end
      end
      ST_RUN: begin
        w_init_busy_nxt = 1'b0;
      end
      default: begin
        w_state_nxt     = ST_INIT;
        w_cnt_nxt       = '0;
        w_init_busy_nxt = 1'b1;
      end
    endcase
  end

  // Write port is owned by the sweep until RUN; CPU writes during INIT are dropped
  always_comb begin
    w_run     = (r_state == ST_RUN);
    w_wa_full = {bus.cpu_bank, bus.cpu_idx};
    w_waddr   = r_cnt;
    w_wdata   = '0;
    w_we_hi   = 1'b1;
    w_we_lo   = 1'b1;
    if (w_run) begin
      w_waddr = w_wa_full[DEPTH_LOG2-1:0];
      w_wdata = bus.cpu_rgb;
      w_we_lo = bus.cpu_wr;
      w_we_hi = bus.cpu_wr && !bus.cpu_loct;
    end
  end

  // EHB reads fold index bit 5 away and remember whether to halve
  always_comb begin
    w_idx_ext = IDX_W'(bus.clut_idx);
    w_ehb_sel = EHB_EN && bus.clut_ehb;
    w_half    = w_ehb_sel && w_idx_ext[5];
    w_ra_ext  = w_idx_ext;
    if (w_ehb_sel) begin
      w_ra_ext[5] = 1'b0;
    end
    w_raddr = w_ra_ext[DEPTH_LOG2-1:0];
    w_re    = bus.clut_rd && w_run;
  end

  clut_ram #(
    .ADDR_W (DEPTH_LOG2)
  ) u_hi_mem (
    .clk     (clk),
    .reset   (reset),
    .i_we    (w_we_hi),
    .i_waddr (w_waddr),
    .i_wdata (w_wdata),
    .i_re    (w_re),
    .i_raddr (w_raddr),
    .o_rdata (w_hi_q)
  );

  clut_ram #(
    .ADDR_W (DEPTH_LOG2)
  ) u_lo_mem (
    .clk     (clk),
    .reset   (reset),
    .i_we    (w_we_lo),
    .i_waddr (w_waddr),
    .i_wdata (w_wdata),
    .i_re    (w_re),
    .i_raddr (w_raddr),
    .o_rdata (w_lo_q)
  );

  // Stage 1 sideband, aligned with the registered RAM outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1 <= '0;
    end else begin
      r_s1.valid <= bus.clut_rd;
      if (bus.clut_rd) begin
        r_s1.half <= w_half;
        r_s1.zero <= !w_run;
      end
    end
  end

  always_comb begin
    w_rgb_asm = interleave(w_hi_q, w_lo_q);
    w_rgb_s2  = w_rgb_asm;
    if (r_s1.zero) begin
      w_rgb_s2 = '0;
    end else if (r_s1.half) begin
      w_rgb_s2 = ehb_half(w_rgb_asm);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_clut_rgb   <= '0;
      r_clut_valid <= 1'b0;
    end else begin
      r_clut_valid <= r_s1.valid;
      if (r_s1.valid) begin
        r_clut_rgb <= w_rgb_s2;
      end
    end
  end

  assign bus.clut_rgb   = r_clut_rgb;
  assign bus.clut_valid = r_clut_valid;
  assign bus.init_busy  = r_init_busy;

endmodule

// File: tb/tb_color_table_aga.sv
// Directed bench: three builds (256/EHB, 256/no-EHB, 32/EHB) driven with shared stimulus.
module tb_color_table_aga;

  logic        clk;
  logic        reset;
  logic        cpu_wr;
  logic [2:0]  cpu_bank;
  logic [4:0]  cpu_idx;
  logic        cpu_loct;
  logic [11:0] cpu_rgb;
  logic        clut_rd;
  logic [7:0]  clut_idx;
  logic        clut_ehb;

  int n_vec;
  int n_err;

  color_table_aga_if #(.DEPTH_LOG2(8)) if_a ();
  color_table_aga_if #(.DEPTH_LOG2(8)) if_b ();
  color_table_aga_if #(.DEPTH_LOG2(5)) if_c ();

  assign if_a.cpu_wr = cpu_wr;   assign if_b.cpu_wr = cpu_wr;   assign if_c.cpu_wr = cpu_wr;
  assign if_a.cpu_bank = cpu_bank; assign if_b.cpu_bank = cpu_bank; assign if_c.cpu_bank = cpu_bank;
  assign if_a.cpu_idx = cpu_idx; assign if_b.cpu_idx = cpu_idx; assign if_c.cpu_idx = cpu_idx;
  assign if_a.cpu_loct = cpu_loct; assign if_b.cpu_loct = cpu_loct; assign if_c.cpu_loct = cpu_loct;
  assign if_a.cpu_rgb = cpu_rgb; assign if_b.cpu_rgb = cpu_rgb; assign if_c.cpu_rgb = cpu_rgb;
  assign if_a.clut_rd = clut_rd; assign if_b.clut_rd = clut_rd; assign if_c.clut_rd = clut_rd;
  assign if_a.clut_ehb = clut_ehb; assign if_b.clut_ehb = clut_ehb; assign if_c.clut_ehb = clut_ehb;
  assign if_a.clut_idx = clut_idx;
  assign if_b.clut_idx = clut_idx;
  assign if_c.clut_idx = clut_idx[4:0];

  color_table_aga #(.DEPTH_LOG2(8), .EHB_EN(1'b1)) u_a (.clk(clk), .reset(reset), .bus(if_a));
  color_table_aga #(.DEPTH_LOG2(8), .EHB_EN(1'b0)) u_b (.clk(clk), .reset(reset), .bus(if_b));
  color_table_aga #(.DEPTH_LOG2(5), .EHB_EN(1'b1)) u_c (.clk(clk), .reset(reset), .bus(if_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [2:0]  bank;
    logic [4:0]  idx;
    logic        loct;
    logic [11:0] rgb;
    logic [7:0]  ridx;
    logic        ehb;
    logic [23:0] exp_a;
    logic [23:0] exp_b;
    logic [23:0] exp_c;
  } vec_t;

  localparam int NV = 15;
  vec_t vecs [NV];

  task automatic chk(input string nm, input logic [23:0] got, input logic [23:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic idle();
    cpu_wr = 1'b0; cpu_bank = 3'd0; cpu_idx = 5'd0; cpu_loct = 1'b0; cpu_rgb = 12'h000;
    clut_rd = 1'b0; clut_idx = 8'd0; clut_ehb = 1'b0;
  endtask

  // Runs from reset release; counts busy cycles and probes INIT-time writes and reads
  task automatic init_sweep(input string tag);
    int ca, cb, cc;
    ca = 0; cb = 0; cc = 0;
    for (int i = 0; i < 300; i++) begin
      ca += int'(if_a.init_busy);
      cb += int'(if_b.init_busy);
      cc += int'(if_c.init_busy);
      if (i < 4) begin
        chk({tag, "_novalid_a"}, 24'(if_a.clut_valid), 24'h0);
        chk({tag, "_novalid_c"}, 24'(if_c.clut_valid), 24'h0);
      end
      if (i == 7) begin
        chk({tag, "_initrd_valid_a"}, 24'(if_a.clut_valid), 24'h1);
        chk({tag, "_initrd_valid_c"}, 24'(if_c.clut_valid), 24'h1);
        chk({tag, "_initrd_rgb_a"}, if_a.clut_rgb, 24'h0);
      end
      if (i == 8) chk({tag, "_initrd_drop_a"}, 24'(if_a.clut_valid), 24'h0);
      clut_rd  = (i == 5);
      clut_idx = 8'd0;
      cpu_wr   = (i == 10);
      cpu_bank = 3'd0; cpu_idx = 5'd7; cpu_loct = 1'b0; cpu_rgb = 12'hFFF;
      @(negedge clk);
    end
    idle();
    chk({tag, "_busy_cycles_a"}, 24'(ca), 24'd256);
    chk({tag, "_busy_cycles_b"}, 24'(cb), 24'd256);
    chk({tag, "_busy_cycles_c"}, 24'(cc), 24'd32);
  endtask

  task automatic run_vec(input vec_t v, input int n);
    cpu_wr = v.wr; cpu_bank = v.bank; cpu_idx = v.idx; cpu_loct = v.loct; cpu_rgb = v.rgb;
    @(negedge clk);
    cpu_wr = 1'b0;
    clut_rd = 1'b1; clut_idx = v.ridx; clut_ehb = v.ehb;
    @(negedge clk);
    clut_rd = 1'b0;
    @(negedge clk);
    chk($sformatf("v%0d_valid_a", n), 24'(if_a.clut_valid), 24'h1);
    chk($sformatf("v%0d_rgb_a", n), if_a.clut_rgb, v.exp_a);
    chk($sformatf("v%0d_rgb_b", n), if_b.clut_rgb, v.exp_b);
    chk($sformatf("v%0d_rgb_c", n), if_c.clut_rgb, v.exp_c);
    @(negedge clk);
    chk($sformatf("v%0d_valid_off_a", n), 24'(if_a.clut_valid), 24'h0);
    chk($sformatf("v%0d_hold_a", n), if_a.clut_rgb, v.exp_a);
  endtask

  logic [23:0] bb_a [4];
  logic [23:0] bb_c [4];

  initial begin
    n_vec = 0;
    n_err = 0;
    idle();
    reset = 1'b1;

    //            wr    bank  idx    loct  rgb      ridx    ehb   exp_a       exp_b       exp_c
    vecs[0]  = '{1'b0, 3'd0, 5'd0, 1'b0, 12'h000, 8'd7,   1'b0, 24'h000000, 24'h000000, 24'h000000};
    vecs[1]  = '{1'b0, 3'd0, 5'd0, 1'b0, 12'h000, 8'd0,   1'b0, 24'h000000, 24'h000000, 24'h000000};
    vecs[2]  = '{1'b0, 3'd0, 5'd0, 1'b0, 12'h000, 8'd128, 1'b0, 24'h000000, 24'h000000, 24'h000000};
    vecs[3]  = '{1'b0, 3'd0, 5'd0, 1'b0, 12'h000, 8'd255, 1'b0, 24'h000000, 24'h000000, 24'h000000};
    vecs[4]  = '{1'b1, 3'd0, 5'd1, 1'b0, 12'hF84, 8'd1,   1'b0, 24'hFF8844, 24'hFF8844, 24'hFF8844};
    vecs[5]  = '{1'b1, 3'd0, 5'd1, 1'b1, 12'h1A2, 8'd1,   1'b0, 24'hF18A42, 24'hF18A42, 24'hF18A42};
    vecs[6]  = '{1'b1, 3'd2, 5'd1, 1'b0, 12'h00F, 8'd65,  1'b0, 24'h0000FF, 24'h0000FF, 24'h0000FF};
    vecs[7]  = '{1'b0, 3'd0, 5'd0, 1'b0, 12'h000, 8'd1,   1'b0, 24'hF18A42, 24'hF18A42, 24'h0000FF};
    vecs[8]  = '{1'b1, 3'd0, 5'd3, 1'b0, 12'hFFF, 8'd35,  1'b1, 24'h7F7F7F, 24'h000000, 24'hFFFFFF};
    vecs[9]  = '{1'b0, 3'd0, 5'd0, 1'b0, 12'h000, 8'd35,  1'b0, 24'h000000, 24'h000000, 24'hFFFFFF};
    vecs[10] = '{1'b0, 3'd0, 5'd0, 1'b0, 12'h000, 8'd3,   1'b1, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF};
    vecs[11] = '{1'b1, 3'd1, 5'd3, 1'b0, 12'h842, 8'd35,  1'b0, 24'h884422, 24'h884422, 24'h884422};
    vecs[12] = '{1'b0, 3'd0, 5'd0, 1'b0, 12'h000, 8'd35,  1'b1, 24'h7F7F7F, 24'h884422, 24'h884422};
    vecs[13] = '{1'b1, 3'd1, 5'd3, 1'b1, 12'h5A6, 8'd35,  1'b0, 24'h854A26, 24'h854A26, 24'h854A26};
    vecs[14] = '{1'b1, 3'd0, 5'd3, 1'b0, 12'h9C3, 8'd35,  1'b1, 24'h4C6619, 24'h854A26, 24'h99CC33};

    bb_a[0] = 24'h000000; bb_a[1] = 24'hF18A42; bb_a[2] = 24'h000000; bb_a[3] = 24'h99CC33;
    bb_c[0] = 24'h000000; bb_c[1] = 24'h0000FF; bb_c[2] = 24'h000000; bb_c[3] = 24'h99CC33;

    repeat (3) @(negedge clk);
    chk("rst_rgb_a", if_a.clut_rgb, 24'h0);
    chk("rst_valid_a", 24'(if_a.clut_valid), 24'h0);
    chk("rst_busy_a", 24'(if_a.init_busy), 24'h1);
    chk("rst_busy_c", 24'(if_c.init_busy), 24'h1);
    reset = 1'b0;
    init_sweep("sweep1");

    for (int n = 0; n < NV; n++) run_vec(vecs[n], n);

    // Read-first on a same-cycle write, then the new value one cycle later
    cpu_wr = 1'b1; cpu_bank = 3'd0; cpu_idx = 5'd9; cpu_loct = 1'b0; cpu_rgb = 12'h123;
    @(negedge clk);
    cpu_rgb = 12'h0F0; clut_rd = 1'b1; clut_idx = 8'd9; clut_ehb = 1'b0;
    @(negedge clk);
    cpu_wr = 1'b0;
    @(negedge clk);
    clut_rd = 1'b0;
    chk("rf_old_valid_a", 24'(if_a.clut_valid), 24'h1);
    chk("rf_old_rgb_a", if_a.clut_rgb, 24'h112233);
    chk("rf_old_rgb_c", if_c.clut_rgb, 24'h112233);
    @(negedge clk);
    chk("rf_new_valid_a", 24'(if_a.clut_valid), 24'h1);
    chk("rf_new_rgb_a", if_a.clut_rgb, 24'h00FF00);
    chk("rf_new_rgb_c", if_c.clut_rgb, 24'h00FF00);
    @(negedge clk);
    chk("rf_end_valid_a", 24'(if_a.clut_valid), 24'h0);

    // Back-to-back reads of entries 0..3
    for (int s = 0; s < 7; s++) begin
      if (s >= 2 && s < 6) begin
        chk($sformatf("bb%0d_valid_a", s - 2), 24'(if_a.clut_valid), 24'h1);
        chk($sformatf("bb%0d_rgb_a", s - 2), if_a.clut_rgb, bb_a[s-2]);
        chk($sformatf("bb%0d_rgb_c", s - 2), if_c.clut_rgb, bb_c[s-2]);
      end
      if (s == 6) chk("bb_end_valid_a", 24'(if_a.clut_valid), 24'h0);
      clut_rd  = (s < 4);
      clut_idx = 8'(s);
      @(negedge clk);
    end

    // Reset lands while reads are still in flight
    clut_rd = 1'b1; clut_idx = 8'd1; clut_ehb = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("mid_pre_rgb_a", if_a.clut_rgb, 24'hF18A42);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_rgb_a", if_a.clut_rgb, 24'h0);
    chk("mid_rst_valid_a", 24'(if_a.clut_valid), 24'h0);
    chk("mid_rst_valid_c", 24'(if_c.clut_valid), 24'h0);
    chk("mid_rst_busy_a", 24'(if_a.init_busy), 24'h1);
    idle();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    init_sweep("sweep2");

    run_vec('{1'b0, 3'd0, 5'd0, 1'b0, 12'h000, 8'd1, 1'b0, 24'h0, 24'h0, 24'h0}, 100);
    run_vec('{1'b0, 3'd0, 5'd0, 1'b0, 12'h000, 8'd3, 1'b0, 24'h0, 24'h0, 24'h0}, 101);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
